// File: rtl/i2s_rx_deserializer.sv
// rtl/i2s_rx_deserializer.sv - Philips I2S receiver forwarding one channel per frame
// Optional slot-length check and sticky frame error: define I2S_RX_FRAMECHK_EN
module i2s_rx_deserializer #(
  parameter int PKT_WIDTH = 16,
  parameter int CHANNEL   = 0
) (
  input  logic                 clkI2SBit_i,
  input  logic                 rstI2S_n_i,
  input  logic                 i2sWS_i,
  input  logic                 i2sSD_i,
  output logic [PKT_WIDTH-1:0] pktI2S_o,
  output logic                 pktValidI2S_o,
`ifdef I2S_RX_FRAMECHK_EN
  output logic                 frameErrI2S_o,
`endif
  output logic                 syncedI2S_o
);

  localparam int CNT_W = $clog2(2*PKT_WIDTH) + 1;
  localparam logic [CNT_W-1:0] CNT_SAT = CNT_W'(2*PKT_WIDTH);
`ifdef I2S_RX_FRAMECHK_EN
  localparam logic [CNT_W-1:0] CNT_GOOD = CNT_W'(PKT_WIDTH-1);
`endif
  localparam logic CH_SEL = (CHANNEL != 0);

  typedef enum logic {SYNC, RUN} state_t;

  state_t               state;
  state_t               stateNext;
  logic [PKT_WIDTH-2:0] shiftReg;
  logic [PKT_WIDTH-1:0] word;
  logic [CNT_W-1:0]     bitCnt;
  logic                 wsDly;
  logic                 wsEdge;
  logic                 emit;
`ifdef I2S_RX_FRAMECHK_EN
  logic                 errSet;
`endif

  // WS leads the MSB by one bit, so the edge cycle samples the LSB of the closing word
  assign wsEdge = (i2sWS_i != wsDly);
  assign word   = {shiftReg, i2sSD_i};

  always_comb begin
    stateNext = state;
    emit      = 1'b0;
`ifdef I2S_RX_FRAMECHK_EN
    errSet    = 1'b0;
`endif
    case (state)
      SYNC: begin
        if (wsEdge) stateNext = RUN;
      end
      RUN: begin
`ifdef I2S_RX_FRAMECHK_EN
        if ((bitCnt == CNT_SAT) || (wsEdge && (bitCnt != CNT_GOOD))) begin
          errSet    = 1'b1;
          stateNext = SYNC;
        end else if (wsEdge && (wsDly == CH_SEL)) begin
          emit = 1'b1;
        end
`else
        if (wsEdge && (wsDly == CH_SEL)) emit = 1'b1;
`endif
      end
      default: stateNext = SYNC;
    endcase
  end

  always_ff @(posedge clkI2SBit_i or negedge rstI2S_n_i) begin
    if (!rstI2S_n_i) begin
      state         <= SYNC;
      shiftReg      <= '0;
      bitCnt        <= '0;
      wsDly         <= 1'b0;
      pktI2S_o      <= '0;
      pktValidI2S_o <= 1'b0;
      syncedI2S_o   <= 1'b0;
`ifdef I2S_RX_FRAMECHK_EN
      frameErrI2S_o <= 1'b0;
`endif
    end else begin
      state         <= stateNext;
      shiftReg      <= word[PKT_WIDTH-2:0];
      wsDly         <= i2sWS_i;
      pktValidI2S_o <= emit;
      syncedI2S_o   <= (stateNext == RUN);
      if (emit) pktI2S_o <= word;
      if (wsEdge) begin
        bitCnt <= '0;
      end else if (bitCnt != CNT_SAT) begin
        bitCnt <= bitCnt + 1'b1;
      end
`ifdef I2S_RX_FRAMECHK_EN
      if (errSet) frameErrI2S_o <= 1'b1;
`endif
    end
  end

endmodule
